// File: rtl/ula_controle_if.sv
// ula_controle_if -- bus bundle between the ula_controle sequencer and its
// environment (host that loads registers / starts instructions, plus the
// downstream combinational ALU that returns resultado).
//
//   master : host + ALU side; drives inicio, instrucao, external write port,
//            debug read address and the ALU result
//   slave  : ula_controle; drives operands, opcode, status flags, debug data
interface ula_controle_if;
  logic       inicio;
  logic [8:0] instrucao;     // [8:6] op, [5:4] rd, [3:2] ra, [1:0] rb
  logic       escrita_en;
  logic [1:0] escrita_end;
  logic [3:0] escrita_dado;
  logic [1:0] leitura_end;
  logic [3:0] leitura_dado;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] seletor;
  logic [3:0] resultado;
  logic       ocupado;
  logic       pronto;
  logic       zero;

  modport master (
    output inicio, instrucao, escrita_en, escrita_end, escrita_dado,
           leitura_end, resultado,
    input  leitura_dado, A, B, seletor, ocupado, pronto, zero
  );

  modport slave (
    input  inicio, instrucao, escrita_en, escrita_end, escrita_dado,
           leitura_end, resultado,
    output leitura_dado, A, B, seletor, ocupado, pronto, zero
  );
endinterface

// File: rtl/ula_controle.sv
// ula_controle -- four-register sequencer feeding an external ALU.
// Each instruction walks OCIOSO -> BUSCA -> EXECUTA -> ESCRITA -> OCIOSO:
// latch instruction, present operands/opcode, capture the ALU result,
// write it back to R[rd] and pulse pronto for one cycle.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ula_controle_if.slave (start/instruction, external register
//           write port, debug read port, ALU operands/opcode/result, flags)
module ula_controle (
  input  logic           clk,
  input  logic           rst_n,
  ula_controle_if.slave  bus
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    BUSCA   = 2'd1,
    EXECUTA = 2'd2,
    ESCRITA = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [8:0] instr_reg;
  logic [3:0] regs [4];
  logic [3:0] a_reg, b_reg, res_reg;
  logic [2:0] sel_reg;
  logic       pronto_reg, zero_reg;

  logic       accept, ext_write, load_ops, cap_res, write_back, busy;

  wire [2:0] op = instr_reg[8:6];
  wire [1:0] rd = instr_reg[5:4];
  wire [1:0] ra = instr_reg[3:2];
  wire [1:0] rb = instr_reg[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= OCIOSO;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OCIOSO:  if (bus.inicio) state_next = BUSCA;
      BUSCA:   state_next = EXECUTA;
      EXECUTA: state_next = ESCRITA;
      ESCRITA: state_next = OCIOSO;
      default: state_next = OCIOSO;
    endcase
  end

  // Output / control decode. The host ports (inicio, escrita_en) are only
  // honoured in OCIOSO, which is what makes them ignored while busy.
  always_comb begin
    accept     = 1'b0;
    ext_write  = 1'b0;
    load_ops   = 1'b0;
    cap_res    = 1'b0;
    write_back = 1'b0;
    case (state_reg)
      OCIOSO: begin
        accept    = bus.inicio;
        ext_write = bus.escrita_en;
      end
      BUSCA:   load_ops   = 1'b1;
      EXECUTA: cap_res    = 1'b1;
      ESCRITA: write_back = 1'b1;
      default: ;
    endcase
    busy = (state_reg != OCIOSO);
  end

  // Register file. External write and writeback live in different states,
  // so they can never collide. An external write on the start edge lands
  // before BUSCA reads operands one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 4'd0;
    end else begin
      if (ext_write)  regs[bus.escrita_end] <= bus.escrita_dado;
      if (write_back) regs[rd]              <= res_reg;
    end
  end

  // Datapath registers; operands/opcode hold until the next BUSCA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg  <= 9'd0;
      a_reg      <= 4'd0;
      b_reg      <= 4'd0;
      sel_reg    <= 3'd0;
      res_reg    <= 4'd0;
      pronto_reg <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      if (accept) instr_reg <= bus.instrucao;
      if (load_ops) begin
        a_reg   <= regs[ra];
        b_reg   <= regs[rb];
        sel_reg <= op;
      end
      if (cap_res) res_reg <= bus.resultado;
      pronto_reg <= write_back;
      if (write_back) zero_reg <= (res_reg == 4'd0);
    end
  end

  assign bus.leitura_dado = regs[bus.leitura_end];
  assign bus.A            = a_reg;
  assign bus.B            = b_reg;
  assign bus.seletor      = sel_reg;
  assign bus.ocupado      = busy;
  assign bus.pronto       = pronto_reg;
  assign bus.zero         = zero_reg;

endmodule

// File: tb/tb_ula_controle.sv
// tb_ula_controle -- self-checking bench for ula_controle.
// A table of instruction vectors is applied in a loop; expected writeback
// values are queued when an instruction is started and popped by a monitor
// on every pronto pulse. Hand-written sequences cover busy-time ignoring,
// back-to-back issue, reset mid-instruction and same-edge write+start.
module tb_ula_controle;

  logic clk;
  logic rst_n;
  ula_controle_if bus ();

  ula_controle dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream ALU model
  always_comb begin
    case (bus.seletor)
      3'b000:  bus.resultado = bus.A & bus.B;
      3'b001:  bus.resultado = bus.A | bus.B;
      3'b010:  bus.resultado = ~bus.A;
      3'b011:  bus.resultado = ~(bus.A & bus.B);
      3'b100:  bus.resultado = bus.A + bus.B;
      3'b101:  bus.resultado = bus.A - bus.B;
      3'b110:  bus.resultado = bus.A << 1;
      default: bus.resultado = bus.A >> 1;
    endcase
  end

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd, ra, rb;
    logic [3:0] va, vb, res;
    logic       z;
  } vec_t;

  typedef struct {
    logic [3:0] res;
    logic       z;
  } exp_t;

  vec_t vecs [9];
  exp_t exp_q [$];
  int   pronto_cyc [$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   pronto_cnt = 0;
  int   kcyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b", name, act, expv);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every pronto must match the oldest started instruction.
  always @(negedge clk) begin
    if (rst_n && bus.pronto) begin
      exp_t e;
      pronto_cnt++;
      pronto_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_pronto: got pronto at cycle %0d expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk4("writeback_value", bus.leitura_dado, e.res);
        chk1("zero_flag", bus.zero, e.z);
        $display("pronto cyc=%0d rd_data=%0h zero=%0b exp=%0h/%0b", cyc, bus.leitura_dado, bus.zero, e.res, e.z);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [3:0] d);
    bus.escrita_en   = 1'b1;
    bus.escrita_end  = a;
    bus.escrita_dado = d;
    step();
    bus.escrita_en   = 1'b0;
  endtask

  // Drives inicio for one edge (edge k); leitura_end follows rd only after
  // edge k so an earlier instruction's pronto still reads its own rd.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [3:0] res, input logic z);
    exp_t e;
    e.res = res;
    e.z   = z;
    bus.instrucao = {op, rd, ra, rb};
    bus.inicio    = 1'b1;
    exp_q.push_back(e);
    step();
    kcyc = cyc;
    bus.inicio      = 1'b0;
    bus.leitura_end = rd;
    chk1("ocupado_after_start", bus.ocupado, 1'b1);
    $display("issue cyc=%0d op=%0b rd=%0d ra=%0d rb=%0d exp=%0h", kcyc, op, rd, ra, rb, res);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 12; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pronto_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic read_reg(input string name, input logic [1:0] a, input logic [3:0] expv);
    bus.leitura_end = a;
    #1;
    chk4(name, bus.leitura_dado, expv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vecs[0] = '{op:3'b100, rd:2'd3, ra:2'd1, rb:2'd2, va:4'd5,  vb:4'd3,  res:4'd8,  z:1'b0};
    vecs[1] = '{op:3'b101, rd:2'd0, ra:2'd1, rb:2'd2, va:4'd3,  vb:4'd5,  res:4'd14, z:1'b0};
    vecs[2] = '{op:3'b000, rd:2'd3, ra:2'd1, rb:2'd2, va:4'hA,  vb:4'h5,  res:4'd0,  z:1'b1};
    vecs[3] = '{op:3'b001, rd:2'd2, ra:2'd0, rb:2'd1, va:4'hA,  vb:4'h5,  res:4'hF,  z:1'b0};
    vecs[4] = '{op:3'b010, rd:2'd1, ra:2'd2, rb:2'd3, va:4'h6,  vb:4'h0,  res:4'h9,  z:1'b0};
    vecs[5] = '{op:3'b011, rd:2'd0, ra:2'd1, rb:2'd3, va:4'hF,  vb:4'hF,  res:4'h0,  z:1'b1};
    vecs[6] = '{op:3'b111, rd:2'd2, ra:2'd3, rb:2'd0, va:4'h8,  vb:4'h0,  res:4'h4,  z:1'b0};
    vecs[7] = '{op:3'b100, rd:2'd1, ra:2'd1, rb:2'd2, va:4'h9,  vb:4'h7,  res:4'h0,  z:1'b1};
    vecs[8] = '{op:3'b110, rd:2'd2, ra:2'd1, rb:2'd0, va:4'h9,  vb:4'h0,  res:4'h2,  z:1'b0};

    rst_n            = 1'b0;
    bus.inicio       = 1'b0;
    bus.instrucao    = 9'd0;
    bus.escrita_en   = 1'b0;
    bus.escrita_end  = 2'd0;
    bus.escrita_dado = 4'd0;
    bus.leitura_end  = 2'd0;

    // Reset state
    #12;
    chk1("rst_ocupado", bus.ocupado, 1'b0);
    chk1("rst_pronto",  bus.pronto,  1'b0);
    chk1("rst_zero",    bus.zero,    1'b0);
    chk4("rst_A",       bus.A,       4'd0);
    chk4("rst_B",       bus.B,       4'd0);
    chk4("rst_seletor", {1'b0, bus.seletor}, 4'd0);
    for (int r = 0; r < 4; r++) read_reg("rst_reg", 2'(r), 4'd0);
    rst_n = 1'b1;

    // Vector table
    for (int v = 0; v < 9; v++) begin
      write_reg(vecs[v].ra, vecs[v].va);
      write_reg(vecs[v].rb, vecs[v].vb);
      issue(vecs[v].op, vecs[v].rd, vecs[v].ra, vecs[v].rb, vecs[v].res, vecs[v].z);
      step();
      chk4("operand_A", bus.A, vecs[v].va);
      chk4("operand_B", bus.B, vecs[v].vb);
      chk4("seletor", {1'b0, bus.seletor}, {1'b0, vecs[v].op});
      wait_done();
    end

    // Busy: second start and external writes ignored during k+1..k+3
    write_reg(2'd1, 4'd2);
    write_reg(2'd2, 4'd4);
    issue(3'b001, 2'd0, 2'd1, 2'd2, 4'd6, 1'b0);
    for (int j = 1; j <= 3; j++) begin
      bus.inicio       = 1'b1;
      bus.instrucao    = {3'b100, 2'd1, 2'd1, 2'd1};
      bus.escrita_en   = 1'b1;
      bus.escrita_end  = 2'd2;
      bus.escrita_dado = 4'hF;
      step();
      chk1("ocupado_busy", bus.ocupado, (j < 3));
    end
    bus.inicio     = 1'b0;
    bus.escrita_en = 1'b0;
    wait_done();
    for (int j = 0; j < 6; j++) step();
    read_reg("busy_r0", 2'd0, 4'd6);
    read_reg("busy_r1", 2'd1, 4'd2);
    read_reg("busy_r2", 2'd2, 4'd4);

    // Back-to-back issue at k and k+4
    write_reg(2'd1, 4'd5);
    write_reg(2'd2, 4'd3);
    pronto_cyc.delete();
    issue(3'b100, 2'd3, 2'd1, 2'd2, 4'd8, 1'b0);
    c0 = kcyc;
    step();
    step();
    step();
    issue(3'b101, 2'd0, 2'd3, 2'd3, 4'd0, 1'b1);
    chk_int("b2b_second_start", kcyc, c0 + 4);
    wait_done();
    chk_int("b2b_pronto_count", pronto_cyc.size(), 2);
    if (pronto_cyc.size() == 2) begin
      chk_int("b2b_pronto_first",  pronto_cyc[0], c0 + 3);
      chk_int("b2b_pronto_second", pronto_cyc[1], c0 + 7);
    end

    // Reset during EXECUTA; external writes must not touch zero
    write_reg(2'd1, 4'd5);
    write_reg(2'd2, 4'd3);
    chk1("zero_kept_on_ext_write", bus.zero, 1'b1);
    issue(3'b100, 2'd3, 2'd1, 2'd2, 4'd8, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    c0 = pronto_cnt;
    chk1("midrst_ocupado", bus.ocupado, 1'b0);
    chk1("midrst_pronto",  bus.pronto,  1'b0);
    chk1("midrst_zero",    bus.zero,    1'b0);
    chk4("midrst_A",       bus.A,       4'd0);
    chk4("midrst_B",       bus.B,       4'd0);
    chk4("midrst_seletor", {1'b0, bus.seletor}, 4'd0);
    step();
    #2;
    rst_n = 1'b1;
    read_reg("midrst_rd_r3", 2'd3, 4'd0);

    // First edge after reset: same-edge external write R1<=9 and SHL start
    bus.escrita_en   = 1'b1;
    bus.escrita_end  = 2'd1;
    bus.escrita_dado = 4'd9;
    issue(3'b110, 2'd2, 2'd1, 2'd0, 4'd2, 1'b0);
    bus.escrita_en   = 1'b0;
    step();
    chk4("simul_A", bus.A, 4'd9);
    wait_done();
    chk_int("midrst_no_pronto", pronto_cnt, c0 + 1);
    read_reg("midrst_r3_after", 2'd3, 4'd0);
    read_reg("simul_r2", 2'd2, 4'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ula_controle.md
ULA_CONTROLE -- requirements
Module: ula_controle

Interface
REQ-001 SHALL have clk, input, 1, single system clock, all state updates on rising edge.
REQ-002 SHALL have rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have inicio, input, 1, start request, sampled only while ocupado=0.
REQ-004 SHALL have instrucao, input, 9, [8:6] op, [5:4] rd, [3:2] ra, [1:0] rb, sampled with inicio.
REQ-005 SHALL have escrita_en, input, 1, external register load enable, honoured only while ocupado=0.
REQ-006 SHALL have escrita_end, input, 2, external load address.
REQ-007 SHALL have escrita_dado, input, 4, external load data.
REQ-008 SHALL have leitura_end, input, 2, debug read address.
REQ-009 SHALL have leitura_dado, output, 4, combinational read of register leitura_end.
REQ-010 SHALL have A, output, 4, registered operand to downstream ALU.
REQ-011 SHALL have B, output, 4, registered operand to downstream ALU.
REQ-012 SHALL have seletor, output, 3, registered ALU opcode (000 AND, 001 OR, 010 NOT A, 011 NAND, 100 ADD, 101 SUB, 110 SHL, 111 SHR).
REQ-013 SHALL have resultado, input, 4, combinational result returned by the ALU.
REQ-014 SHALL have ocupado, output, 1, busy flag.
REQ-015 SHALL have pronto, output, 1, one-cycle completion pulse.
REQ-016 SHALL have zero, output, 1, registered flag, 1 when last written-back result = 0.

Function
REQ-017 SHALL contain four 4-bit registers R0..R3, all writable and readable.
REQ-018 SHALL implement FSM OCIOSO -> BUSCA -> EXECUTA -> ESCRITA -> OCIOSO, one cycle per state except OCIOSO.
REQ-019 SHALL, at edge k with state OCIOSO and inicio=1, latch instrucao, set ocupado=1, go to BUSCA.
REQ-020 SHALL, at edge k+1 (BUSCA), load A<=R[ra], B<=R[rb], seletor<=op, go to EXECUTA.
REQ-021 SHALL, at edge k+2 (EXECUTA), capture resultado into an internal result register, go to ESCRITA.
REQ-022 SHALL, at edge k+3 (ESCRITA), write result to R[rd], update zero, assert pronto for exactly the cycle after k+3, clear ocupado, return to OCIOSO.
REQ-023 SHALL hold A, B, seletor stable from edge k+1 until the next instruction's BUSCA edge.
REQ-024 SHALL ignore inicio while ocupado=1; no queuing.
REQ-025 SHALL ignore escrita_en while ocupado=1; no register changes except REQ-022 writeback.
REQ-026 SHALL, when escrita_en=1 and inicio=1 at the same idle edge, perform the external write at that edge and start the instruction; operand read in BUSCA sees the new value.
REQ-027 SHALL accept a new inicio at edge k+4 (first idle edge after writeback), giving one instruction per 4 cycles peak.
REQ-028 SHALL permit rd equal to ra or rb; operands are those read in BUSCA, write occurs in ESCRITA.
REQ-029 SHALL treat all arithmetic as 4-bit modulo 16, no carry/borrow output; width handling belongs to the ALU.
REQ-030 SHALL keep zero unchanged between writebacks and unaffected by external writes.

Reset
REQ-031 SHALL, on rst_n=0, immediately clear R0..R3, A, B, seletor, result register, ocupado, pronto, zero to 0 and force state OCIOSO.
REQ-032 SHALL, on reset mid-instruction, abort with no writeback and no pronto pulse.
REQ-033 SHALL leave the block idle and accepting inicio on the first rising edge after rst_n returns to 1.

Verification
REQ-034 SHALL cover: load R1=5, R2=3; inicio op=100 rd=3 ra=1 rb=2 -> A=5,B=3,seletor=100 after edge k+1; R3=8, pronto one cycle, zero=0 after k+3.
REQ-035 SHALL cover: R1=3, R2=5; op=101 rd=0 ra=1 rb=2 -> R0=14 (1110), zero=0; then op=000 with R1=4'b1010, R2=4'b0101 -> result 0, zero=1.
REQ-036 SHALL cover: second inicio and escrita_en at edges k+1..k+3 of an active instruction -> both ignored, only rd written, ocupado continuous 1 until after k+3.
REQ-037 SHALL cover: rst_n pulsed low during EXECUTA -> all outputs 0 immediately, destination register stays 0, no pronto.
REQ-038 SHALL cover: simultaneous idle escrita_en (R1<=9) and inicio op=110 rd=2 ra=1 -> R2=2 (9 shifted left, modulo 16).
REQ-039 SHALL cover: back-to-back instructions with inicio at k and k+4 -> both complete, pronto at cycles k+3 and k+7.
